// File: rtl/lab4d_pkg.sv
// lab4d_pkg: constants and FSM state encoding shared by the LAB4D readout path.
package lab4d_pkg;

  localparam int NBITS     = 12;
  localparam int LAB_COUNT = 12;
  localparam int WIN_W     = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT_HI,
    ST_SHIFT_LO,
    ST_WRITE,
    ST_INCR_HI,
    ST_INCR_LO,
    ST_DONE
  } state_e;

endpackage

// File: rtl/lab4d_doe_deser.sv
// lab4d_doe_deser: one chip's DOE shift register; bits enter at the LSB so the
// first (MSB) bit ends up at the top after NBITS shifts.
module lab4d_doe_deser #(
  parameter int NBITS = lab4d_pkg::NBITS
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             shift_en_i,
  input  logic             din_i,
  output logic [NBITS-1:0] word_o
);

  logic [NBITS-1:0] word_q, word_d;

  always_comb begin
    word_d = word_q;
    if (shift_en_i) begin
      word_d = {word_q[NBITS-2:0], din_i};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      word_q <= '0;
    end else begin
      word_q <= word_d;
    end
  end

  assign word_o = word_q;

endmodule

// File: rtl/lab4d_readout.sv
// lab4d_readout: clocks one window out of 12 LAB4D chips and emits one 144-bit beat per sample.
// Optional build macro LAB4D_READOUT_TESTPAT_EN: test_i latched at start selects a synthetic pattern.
module lab4d_readout
  import lab4d_pkg::*;
#(
  parameter int SAMPLES_PER_WINDOW = 64,
  parameter int NBITS              = lab4d_pkg::NBITS
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       readout_i,
  input  logic [WIN_W-1:0]           readout_address_i,
  input  logic [3:0]                 prescale_i,
  output logic                       complete_o,
  output logic                       busy_o,
  input  logic                       test_i,
  output logic [LAB_COUNT-1:0]       SS_INCR,
  output logic [LAB_COUNT-1:0]       SRCLK,
  input  logic [LAB_COUNT-1:0]       DOE,
  output logic                       wr_o,
  output logic [LAB_COUNT*NBITS-1:0] dat_o,
  output logic [6:0]                 sample_o,
  output logic [WIN_W-1:0]           window_o,
  input  logic                       full_i
);

  localparam logic [3:0] LAST_BIT    = 4'(NBITS);
  localparam logic [6:0] LAST_SAMPLE = 7'(SAMPLES_PER_WINDOW - 1);

  state_e                     state_q, state_d;
  logic [3:0]                 phase_q, phase_d;
  logic [3:0]                 bitcnt_q, bitcnt_d;
  logic [6:0]                 sample_q, sample_d;
  logic [WIN_W-1:0]           window_q, window_d;
  logic [3:0]                 presc_q, presc_d;
  logic                       srclk_q, srclk_d;
  logic                       ss_incr_q, ss_incr_d;
  logic                       wr_q, wr_d;
  logic                       complete_q, complete_d;
  logic [LAB_COUNT*NBITS-1:0] dat_q, dat_d;
  logic [LAB_COUNT*NBITS-1:0] word_bus;
  logic                       shift_en;
  logic                       phase_last;

`ifdef LAB4D_READOUT_TESTPAT_EN
  logic test_q, test_d;
`else
  logic unused_test;
  assign unused_test = test_i;
`endif

  assign phase_last = (phase_q == presc_q);

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    bitcnt_d = bitcnt_q;
    sample_d = sample_q;
    window_d = window_q;
    presc_d  = presc_q;
    shift_en = 1'b0;
`ifdef LAB4D_READOUT_TESTPAT_EN
    test_d   = test_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (readout_i) begin
          state_d  = ST_SHIFT_HI;
          window_d = readout_address_i;
          presc_d  = prescale_i;
          sample_d = '0;
          bitcnt_d = '0;
          phase_d  = '0;
`ifdef LAB4D_READOUT_TESTPAT_EN
          test_d   = test_i;
`endif
        end
      end
      ST_SHIFT_HI: begin
        if (phase_last) begin
          // DOE is captured at the end of the high phase, just before SRCLK falls.
          shift_en = 1'b1;
          bitcnt_d = bitcnt_q + 4'd1;
          phase_d  = '0;
          state_d  = ST_SHIFT_LO;
        end else begin
          phase_d = phase_q + 4'd1;
        end
      end
      ST_SHIFT_LO: begin
        if (phase_last) begin
          phase_d = '0;
          state_d = (bitcnt_q < LAST_BIT) ? ST_SHIFT_HI : ST_WRITE;
        end else begin
          phase_d = phase_q + 4'd1;
        end
      end
      ST_WRITE: begin
        if (wr_q) begin
          phase_d = '0;
          state_d = (sample_q == LAST_SAMPLE) ? ST_DONE : ST_INCR_HI;
        end
      end
      ST_INCR_HI: begin
        if (phase_last) begin
          phase_d = '0;
          state_d = ST_INCR_LO;
        end else begin
          phase_d = phase_q + 4'd1;
        end
      end
      ST_INCR_LO: begin
        if (phase_last) begin
          phase_d  = '0;
          bitcnt_d = '0;
          sample_d = sample_q + 7'd1;
          state_d  = ST_SHIFT_HI;
        end else begin
          phase_d = phase_q + 4'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Outputs decode the next state so every strobe comes straight from a flop.
    srclk_d    = (state_d == ST_SHIFT_HI);
    ss_incr_d  = (state_d == ST_INCR_HI);
    complete_d = (state_d == ST_DONE);
    wr_d       = (state_d == ST_WRITE) && !full_i;
    dat_d      = (state_d == ST_WRITE) ? word_bus : '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      phase_q    <= '0;
      bitcnt_q   <= '0;
      sample_q   <= '0;
      window_q   <= '0;
      presc_q    <= '0;
      srclk_q    <= 1'b0;
      ss_incr_q  <= 1'b0;
      wr_q       <= 1'b0;
      complete_q <= 1'b0;
      dat_q      <= '0;
`ifdef LAB4D_READOUT_TESTPAT_EN
      test_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      bitcnt_q   <= bitcnt_d;
      sample_q   <= sample_d;
      window_q   <= window_d;
      presc_q    <= presc_d;
      srclk_q    <= srclk_d;
      ss_incr_q  <= ss_incr_d;
      wr_q       <= wr_d;
      complete_q <= complete_d;
      dat_q      <= dat_d;
`ifdef LAB4D_READOUT_TESTPAT_EN
      test_q     <= test_d;
`endif
    end
  end

  for (genvar gi = 0; gi < LAB_COUNT; gi++) begin : g_lab
    logic [NBITS-1:0] word;

    lab4d_doe_deser #(.NBITS(NBITS)) u_deser (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .shift_en_i (shift_en),
      .din_i      (DOE[gi]),
      .word_o     (word)
    );

`ifdef LAB4D_READOUT_TESTPAT_EN
    assign word_bus[gi*NBITS +: NBITS] = test_q ?
        NBITS'({4'(gi) ^ window_q[3:0], sample_q[5:0], 2'b00}) : word;
`else
    assign word_bus[gi*NBITS +: NBITS] = word;
`endif
  end

  assign SRCLK      = {LAB_COUNT{srclk_q}};
  assign SS_INCR    = {LAB_COUNT{ss_incr_q}};
  assign wr_o       = wr_q;
  assign complete_o = complete_q;
  assign dat_o      = dat_q;
  assign sample_o   = sample_q;
  assign window_o   = window_q;
  assign busy_o     = (state_q != ST_IDLE);

endmodule
